// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator driven by a pixel-rate enable on the system clock.
// Produces registered sync, blanking, active-area coordinates and line/frame start strobes.
module vga_timing_gen #(
  parameter int unsigned H_PW   = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned H_DISP = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned V_PW   = 2,
  parameter int unsigned V_BP   = 33,
  parameter int unsigned V_DISP = 480,
  parameter int unsigned V_FP   = 10,
  parameter bit          H_POL  = 1'b0,
  parameter bit          V_POL  = 1'b0,
  parameter int unsigned CNT_W  = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_PW + H_BP + H_DISP + H_FP;
  localparam int unsigned V_TOTAL = V_PW + V_BP + V_DISP + V_FP;
  localparam int unsigned HActS   = H_PW + H_BP;
  localparam int unsigned HActE   = HActS + H_DISP;
  localparam int unsigned VActS   = V_PW + V_BP;
  localparam int unsigned VActE   = VActS + V_DISP;

  localparam longint unsigned CntRange = 64'd1 << CNT_W;

  localparam logic [CNT_W-1:0] HMax = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VMax = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HOff = CNT_W'(HActS);
  localparam logic [CNT_W-1:0] VOff = CNT_W'(VActS);

  if (64'(H_TOTAL) > CntRange || 64'(V_TOTAL) > CntRange) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CNT_W-1:0] cnt_x_q, cnt_x_d;
  logic [CNT_W-1:0] cnt_y_q, cnt_y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  // Compare in 32 bits so active-window bounds equal to 2^CNT_W cannot truncate.
  logic [31:0] cx_ext, cy_ext;
  logic        h_act, v_act;

  assign cx_ext = 32'(cnt_x_q);
  assign cy_ext = 32'(cnt_y_q);
  assign h_act  = (cx_ext >= HActS) && (cx_ext < HActE);
  assign v_act  = (cy_ext >= VActS) && (cy_ext < VActE);

  always_comb begin
    cnt_x_d       = cnt_x_q;
    cnt_y_d       = cnt_y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en) begin
      hsync_d       = (cx_ext < H_PW) ? H_POL : ~H_POL;
      vsync_d       = (cy_ext < V_PW) ? V_POL : ~V_POL;
      video_on_d    = h_act && v_act;
      x_d           = (h_act && v_act) ? cnt_x_q - HOff : '0;
      y_d           = (h_act && v_act) ? cnt_y_q - VOff : '0;
      line_start_d  = (cnt_x_q == '0);
      frame_start_d = (cnt_x_q == '0) && (cnt_y_q == '0);
      if (cnt_x_q == HMax) begin
        cnt_x_d = '0;
        cnt_y_d = (cnt_y_q == VMax) ? '0 : cnt_y_q + CNT_W'(1);
      end else begin
        cnt_x_d = cnt_x_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_x_q       <= '0;
      cnt_y_q       <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      video_on_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_x_q       <= cnt_x_d;
      cnt_y_q       <= cnt_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny 8x6 instance, both checked
// every clock against expectations queued at drive time.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        von;
    logic        ls;
    logic        fs;
    logic [10:0] x;
    logic [10:0] y;
  } out_t;

  typedef struct {
    bit          hs;
    bit          von;
    logic [10:0] x;
  } hrow_t;

  typedef struct {
    bit          vs;
    bit          von;
    logic [10:0] y;
  } vrow_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1, en_d = 1'b0, rst_s = 1'b1, en_s = 1'b0;
  logic hsync_d, vsync_d, von_d, ls_d, fs_d;
  logic hsync_s, vsync_s, von_s, ls_s, fs_s;
  logic [10:0] x_d, y_d, x_s, y_s;

  vga_timing_gen u_dflt (
    .clk        (clk),
    .rst        (rst_d),
    .pix_en     (en_d),
    .hsync      (hsync_d),
    .vsync      (vsync_d),
    .video_on   (von_d),
    .x          (x_d),
    .y          (y_d),
    .line_start (ls_d),
    .frame_start(fs_d)
  );

  vga_timing_gen #(
    .H_PW(2), .H_BP(1), .H_DISP(4), .H_FP(1),
    .V_PW(1), .V_BP(1), .V_DISP(3), .V_FP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(11)
  ) u_small (
    .clk        (clk),
    .rst        (rst_s),
    .pix_en     (en_s),
    .hsync      (hsync_s),
    .vsync      (vsync_s),
    .video_on   (von_s),
    .x          (x_s),
    .y          (y_s),
    .line_start (ls_s),
    .frame_start(fs_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  out_t q_d[$];
  out_t q_s[$];
  out_t prev_d, prev_s, got_d, got_s;
  int   mx = 0, my = 0, sx = 0, sy = 0;
  int   seq_fail_d = 0, seq_fail_s = 0;

  hrow_t htab[8];
  vrow_t vtab[6];

  localparam out_t RstD = '{hs: 1'b1, vs: 1'b1, von: 1'b0, ls: 1'b0, fs: 1'b0, x: '0, y: '0};
  localparam out_t RstS = '{hs: 1'b0, vs: 1'b0, von: 1'b0, ls: 1'b0, fs: 1'b0, x: '0, y: '0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_out(input string name, input out_t got, input out_t exp, inout int nf);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      nf++;
      if (nf <= 10)
        $display("FAIL %s: got hs%b vs%b von%b ls%b fs%b x%0d y%0d expected hs%b vs%b von%b ls%b fs%b x%0d y%0d",
                 name, got.hs, got.vs, got.von, got.ls, got.fs, got.x, got.y,
                 exp.hs, exp.vs, exp.von, exp.ls, exp.fs, exp.x, exp.y);
    end
  endtask

  // Default 640x480, active-low syncs: sync 0..95, back porch 96..143, display 144..783.
  function automatic out_t model_d(input int cx, input int cy);
    out_t o;
    o.hs  = (cx >= 96);
    o.vs  = (cy >= 2);
    o.von = (cx >= 144) && (cx < 784) && (cy >= 35) && (cy < 515);
    o.x   = o.von ? 11'(cx - 144) : 11'd0;
    o.y   = o.von ? 11'(cy - 35) : 11'd0;
    o.ls  = (cx == 0);
    o.fs  = (cx == 0) && (cy == 0);
    return o;
  endfunction

  function automatic out_t model_s(input int cx, input int cy);
    out_t o;
    o.hs  = htab[cx].hs;
    o.vs  = vtab[cy].vs;
    o.von = htab[cx].von && vtab[cy].von;
    o.x   = o.von ? htab[cx].x : 11'd0;
    o.y   = o.von ? vtab[cy].y : 11'd0;
    o.ls  = (cx == 0);
    o.fs  = (cx == 0) && (cy == 0);
    return o;
  endfunction

  task automatic drive_d(input bit r, input bit e);
    out_t ex;
    if (r) begin
      ex = RstD; mx = 0; my = 0;
    end else if (e) begin
      ex = model_d(mx, my);
      if (mx == 799) begin mx = 0; my = (my == 524) ? 0 : my + 1; end
      else mx++;
    end else begin
      ex = prev_d; ex.ls = 1'b0; ex.fs = 1'b0;
    end
    prev_d = ex;
    q_d.push_back(ex);
    rst_d = r; en_d = e;
    @(posedge clk);
    @(negedge clk);
    got_d = {hsync_d, vsync_d, von_d, ls_d, fs_d, x_d, y_d};
    check_out("dflt_seq", got_d, q_d.pop_front(), seq_fail_d);
  endtask

  task automatic drive_s(input bit r, input bit e);
    out_t ex;
    if (r) begin
      ex = RstS; sx = 0; sy = 0;
    end else if (e) begin
      ex = model_s(sx, sy);
      if (sx == 7) begin sx = 0; sy = (sy == 5) ? 0 : sy + 1; end
      else sx++;
    end else begin
      ex = prev_s; ex.ls = 1'b0; ex.fs = 1'b0;
    end
    prev_s = ex;
    q_s.push_back(ex);
    rst_s = r; en_s = e;
    @(posedge clk);
    @(negedge clk);
    got_s = {hsync_s, vsync_s, von_s, ls_s, fs_s, x_s, y_s};
    check_out("small_seq", got_s, q_s.pop_front(), seq_fail_s);
  endtask

  initial begin
    int last;
    htab = '{'{1, 0, 0}, '{1, 0, 0}, '{0, 0, 0}, '{0, 1, 0},
             '{0, 1, 1}, '{0, 1, 2}, '{0, 1, 3}, '{0, 0, 0}};
    vtab = '{'{1, 0, 0}, '{0, 0, 0}, '{0, 1, 0}, '{0, 1, 1}, '{0, 1, 2}, '{0, 0, 0}};

    // Default instance, pix_en held high through line 35.
    drive_d(1, 0);
    drive_d(1, 0);
    check("dflt_reset_hs_vs", {30'd0, got_d.hs, got_d.vs}, 32'h3);
    last = -1;
    for (int k = 1; k <= 28800; k++) begin
      drive_d(0, 1);
      if (k == 1)     check("first_px_hs_vs_ls_fs", {got_d.hs, got_d.vs, got_d.ls, got_d.fs}, 4'b0011);
      if (k == 96)    check("hsync_last_low", got_d.hs, 0);
      if (k == 97)    check("hsync_high", got_d.hs, 1);
      if (k == 1600)  check("vsync_last_low", got_d.vs, 0);
      if (k == 1601)  check("vsync_high", got_d.vs, 1);
      if (k == 28144) check("von_before_144", got_d.von, 0);
      if (k == 28145) check("von_rise_x0", {got_d.von, got_d.x, got_d.y}, {1'b1, 11'd0, 11'd0});
      if (k == 28784) check("x_639", {got_d.von, got_d.x}, {1'b1, 11'd639});
      if (k == 28785) check("von_fall", {got_d.von, got_d.x}, {1'b0, 11'd0});
      if (got_d.ls) begin
        if (last >= 0 && (k % 4000 == 1 || k == 801)) check("ls_period_800", k - last, 800);
        last = k;
      end
    end

    // Mid-frame reset (line 36), then restart at pixel (0,0).
    drive_d(1, 0);
    check("midreset_vals", got_d, RstD);
    drive_d(0, 1);
    check("midreset_first", {got_d.fs, got_d.ls, got_d.hs, got_d.vs}, 4'b1100);

    // Reset and pix_en together: no advance.
    drive_d(1, 1);
    check("rst_en_vals", got_d, RstD);
    drive_d(0, 1);
    check("rst_en_no_adv", {got_d.fs, got_d.x}, {1'b1, 11'd0});

    // pix_en every 4th clock.
    drive_d(1, 0);
    last = -1;
    for (int k = 1; k <= 3300; k++) begin
      drive_d(0, (k % 4) == 0);
      if (got_d.ls) begin
        if (last >= 0) check("ls_period_3200", k - last, 3200);
        last = k;
      end
    end
    check("ls_seen_every4", last, 3204);

    // Small instance: two frames plus one pixel.
    drive_s(1, 0);
    check("small_reset_vals", got_s, RstS);
    last = -1;
    for (int k = 1; k <= 97; k++) begin
      drive_s(0, 1);
      if (got_s.fs) begin
        if (last >= 0) check("fs_period_48", k - last, 48);
        last = k;
      end
    end
    check("fs_last_seen", last, 97);

    // Random enables on the small instance.
    for (int k = 0; k < 120; k++) drive_s(0, 1'($urandom_range(0, 1)));

    // Small mid-frame reset, one idle clock, then pixel (0,0) with active-high syncs.
    for (int k = 0; k < 21; k++) drive_s(0, 1);
    drive_s(1, 0);
    drive_s(0, 0);
    check("small_hold_after_rst", got_s, RstS);
    drive_s(0, 1);
    check("small_restart", {got_s.fs, got_s.hs, got_s.vs}, 3'b111);

    check("queues_drained", q_d.size() + q_s.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
